// File: rtl/conv_window_feeder.sv
// conv_window_feeder
// Producer side of the conv unit's image interface. Accepts a raster pixel
// stream (ready/valid), keeps the last (F-1)*IMG_W+F pixels in a shift
// register and, whenever an accepted pixel completes an FxF stride-1 window,
// freezes the stream for one conv slot: 2 cycles of conv_reset followed by
// F*F MAC cycles, with win_done on the last one.
//
// Ports
//   clk         in   clock, rising edge
//   reset       in   asynchronous, active-high reset
//   px_in       in   pixel, raster order
//   px_valid    in   px_in valid
//   px_ready    out  pixel accepted this cycle when px_valid is also high
//   win_image   out  flattened window, element r*F+c at [DATA_WIDTH*i +: DATA_WIDTH]
//   win_valid   out  window stable and owned by the conv unit
//   conv_reset  out  conv unit reset
//   win_done    out  1-cycle pulse, conv result for this window is final
//   frame_done  out  1-cycle pulse with win_done of the frame's last window
module conv_window_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int F          = 3,
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_WIDTH-1:0]         px_in,
  input  logic                          px_valid,
  output logic                          px_ready,
  output logic [0:F*F*DATA_WIDTH-1]     win_image,
  output logic                          win_valid,
  output logic                          conv_reset,
  output logic                          win_done,
  output logic                          frame_done
);

  localparam int SR_LEN = (F - 1) * IMG_W + F;
  localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int CNT_W  = $clog2(F * F);

  localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);
  localparam logic [COL_W-1:0] COL_WIN   = COL_W'(F - 1);
  localparam logic [ROW_W-1:0] ROW_WIN   = ROW_W'(F - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(F * F - 1);
  localparam logic [CNT_W-1:0] HOLD_PRE  = CNT_W'(F * F - 2);

  typedef enum logic [1:0] {S_ACCEPT, S_RST, S_HOLD} state_t;

  state_t                         state_q;
  logic [COL_W-1:0]               col_q;
  logic [ROW_W-1:0]               row_q;
  logic [CNT_W-1:0]               cnt_q;
  logic                           last_q;
  logic                           px_ready_q;
  logic                           conv_reset_q;
  logic                           win_valid_q;
  logic                           win_done_q;
  logic                           frame_done_q;
  logic [SR_LEN*DATA_WIDTH-1:0]   sr_q;
  logic                           handshake;
  logic                           completes;

  // px_ready_q is high exactly in ACCEPT, so this is the accept condition.
  assign handshake = px_ready_q & px_valid;
  assign completes = (row_q >= ROW_WIN) && (col_q >= COL_WIN);

  // Newest pixel sits in slot 0; the register only moves on a handshake,
  // which freezes the window for the whole RST/HOLD slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_q <= '0;
    end else if (handshake) begin
      sr_q <= {sr_q[(SR_LEN-1)*DATA_WIDTH-1:0], px_in};
    end
  end

  // Window element (r,c): the newest pixel is the bottom-right corner, each
  // row up is IMG_W pixels older, each column left is one pixel older.
  generate
    for (genvar gi = 0; gi < F * F; gi++) begin : g_tap
      localparam int AGE = (F - 1 - gi / F) * IMG_W + (F - 1 - gi % F);
      assign win_image[DATA_WIDTH*gi +: DATA_WIDTH] = sr_q[AGE*DATA_WIDTH +: DATA_WIDTH];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_ACCEPT;
      col_q        <= '0;
      row_q        <= '0;
      cnt_q        <= '0;
      last_q       <= 1'b0;
      px_ready_q   <= 1'b1;
      conv_reset_q <= 1'b0;
      win_valid_q  <= 1'b0;
      win_done_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      win_done_q   <= 1'b0;
      frame_done_q <= 1'b0;
      case (state_q)
        S_ACCEPT: begin
          if (handshake) begin
            if (col_q == COL_LAST) begin
              col_q <= '0;
              row_q <= (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
            end else begin
              col_q <= col_q + COL_W'(1);
            end
            if (completes) begin
              state_q      <= S_RST;
              cnt_q        <= '0;
              // Counters wrap on this edge, so remember the frame end now.
              last_q       <= (row_q == ROW_LAST) && (col_q == COL_LAST);
              px_ready_q   <= 1'b0;
              conv_reset_q <= 1'b1;
              win_valid_q  <= 1'b1;
            end
          end
        end
        S_RST: begin
          if (cnt_q == CNT_W'(1)) begin
            state_q      <= S_HOLD;
            cnt_q        <= '0;
            conv_reset_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_HOLD: begin
          // Pulses are set one edge early so they land on the last HOLD cycle.
          if (cnt_q == HOLD_PRE) begin
            win_done_q   <= 1'b1;
            frame_done_q <= last_q;
          end
          if (cnt_q == HOLD_LAST) begin
            state_q     <= S_ACCEPT;
            cnt_q       <= '0;
            px_ready_q  <= 1'b1;
            win_valid_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= S_ACCEPT;
        end
      endcase
    end
  end

  assign px_ready   = px_ready_q;
  assign win_valid  = win_valid_q;
  // The conv unit must also be held in reset while this block is.
  assign conv_reset = reset | conv_reset_q;
  assign win_done   = win_done_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_window_feeder.sv
module tb_conv_window_feeder;
  localparam int DW = 8;
  localparam int F  = 3;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int NB = F * F * DW;

  logic          clk;
  logic          reset;
  logic [DW-1:0] px_in;
  logic          px_valid;
  logic          px_ready;
  logic [0:NB-1] win_image;
  logic          win_valid;
  logic          conv_reset;
  logic          win_done;
  logic          frame_done;

  conv_window_feeder #(.DATA_WIDTH(DW), .F(F), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .reset(reset), .px_in(px_in), .px_valid(px_valid), .px_ready(px_ready),
    .win_image(win_image), .win_valid(win_valid), .conv_reset(conv_reset),
    .win_done(win_done), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int wins  = 0;
  int frames = 0;
  int pos   = 0;

  typedef struct {
    logic [0:NB-1] img;
    logic          last;
  } exp_t;
  exp_t expq[$];

  // Hand-computed windows for a 4x4 frame of pixels 1..16.
  int win_tab [4][9] = '{
    '{1, 2, 3, 5, 6, 7, 9, 10, 11},
    '{2, 3, 4, 6, 7, 8, 10, 11, 12},
    '{5, 6, 7, 9, 10, 11, 13, 14, 15},
    '{6, 7, 8, 10, 11, 12, 14, 15, 16}
  };

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Push the expected window when the pixel at frame position p completes one.
  task automatic push_if_window(input int p, input int base);
    int r, c, widx;
    exp_t e;
    r = p / W;
    c = p % W;
    if (r >= F - 1 && c >= F - 1) begin
      widx = (r - (F - 1)) * (W - F + 1) + (c - (F - 1));
      for (int i = 0; i < F * F; i++) e.img[DW*i +: DW] = DW'(win_tab[widx][i] + base);
      e.last = (widx == 3);
      expq.push_back(e);
    end
  endtask

  task automatic send(input int v, input int base, output int cycles);
    logic hs;
    px_in = DW'(v);
    px_valid = 1'b1;
    cycles = 0;
    hs = 1'b0;
    while (!hs && cycles < 60) begin
      @(negedge clk);
      hs = px_ready;
      @(posedge clk);
      #1;
      cycles++;
    end
    px_valid = 1'b0;
    if (!hs) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: pixel %0d not accepted within %0d cycles", v, cycles);
    end else begin
      push_if_window(pos, base);
      pos = (pos + 1) % (W * H);
    end
  endtask

  task automatic send_frame(input int base, input bit gapped);
    int cyc;
    for (int i = 0; i < W * H; i++) begin
      send(base + i + 1, base, cyc);
      if (gapped) begin
        px_in = 8'hEE;
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    while (!px_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!px_ready) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: px_ready still %0b after %0d cycles", px_ready, n);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on every win_done and checks slot timing.
  initial begin
    int lowrun, crrun;
    exp_t e;
    lowrun = 0;
    crrun = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        lowrun = 0;
        crrun = 0;
      end else begin
        if (!px_ready) lowrun++;
        else if (lowrun != 0) begin
          chk("ready_low_cycles", lowrun, 11);
          lowrun = 0;
        end
        if (conv_reset) crrun++;
        else if (crrun != 0) begin
          chk("conv_reset_cycles", crrun, 2);
          crrun = 0;
        end
        chk("win_valid_vs_ready", win_valid, !px_ready);
        if (frame_done) frames++;
        if (win_done) begin
          wins++;
          if (expq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_win_done: got window %0h expected none", win_image);
          end else begin
            e = expq.pop_front();
            chk("win_image", win_image, e.img);
            chk("frame_done", frame_done, e.last);
          end
        end else if (frame_done) begin
          total++;
          bad++;
          $display("FAIL frame_done_alone: got frame_done=1 expected 0 without win_done");
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc;
    reset = 1'b1;
    px_valid = 1'b0;
    px_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_px_ready", px_ready, 1);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_conv_reset", conv_reset, 1);
    chk("rst_win_done", win_done, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_win_image", win_image, 0);
    reset = 1'b0;
    #1;
    chk("accept_conv_reset", conv_reset, 0);
    @(posedge clk);
    #1;

    // Frame 1, continuous: first ten pixels complete no window.
    pos = 0;
    for (int i = 1; i <= 10; i++) begin
      send(i, 0, cyc);
      chk("nowin_accept_cycles", cyc, 1);
      chk("nowin_px_ready", px_ready, 1);
      chk("nowin_win_valid", win_valid, 0);
    end
    send(11, 0, cyc);
    chk("p11_accept_cycles", cyc, 1);
    chk("p11_conv_reset", conv_reset, 1);
    chk("p11_px_ready", px_ready, 0);
    chk("p11_win_valid", win_valid, 1);
    for (int i = 12; i <= 16; i++) send(i, 0, cyc);
    drain();
    chk("frame1_windows", wins, 4);
    chk("frame1_frame_done", frames, 1);

    // Frame 2 back-to-back, pixels 17..32.
    send_frame(16, 1'b0);
    drain();
    chk("frame2_windows", wins, 8);
    chk("frame2_frame_done", frames, 2);

    // Gapped px_valid after a fresh reset.
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    pos = 0;
    send_frame(0, 1'b1);
    drain();
    chk("gapped_windows", wins, 12);
    chk("gapped_frame_done", frames, 3);

    // Reset during the 5th HOLD cycle of window 1.
    for (int i = 1; i <= 11; i++) send(i, 0, cyc);
    repeat (6) @(posedge clk);
    #1;
    chk("prehold_win_valid", win_valid, 1);
    reset = 1'b1;
    #1;
    chk("abort_conv_reset", conv_reset, 1);
    chk("abort_win_valid", win_valid, 0);
    chk("abort_win_done", win_done, 0);
    chk("abort_px_ready", px_ready, 1);
    chk("abort_win_image", win_image, 0);
    expq.delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    pos = 0;
    chk("abort_no_extra_win", wins, 12);
    send_frame(0, 1'b0);
    drain();
    chk("resend_windows", wins, 16);
    chk("resend_frame_done", frames, 4);
    chk("queue_empty", expq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
